// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_bridge shared definitions: frame geometry, command bit position,
// frame FSM encoding and a counter-width helper.
package spi_reg_bridge_pkg;

    localparam int FRAME_BITS = 24;
    localparam int CMD_BITS   = 8;

    // W is frame bit 23; after CMD_BITS shifts it sits here in rx.
    localparam int W_BIT     = 23;
    localparam int W_CMD_POS = W_BIT - (FRAME_BITS - CMD_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_WAIT,
        ST_DATA,
        ST_DONE
    } frame_st_e;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third flop for rise/fall pulses.
// Ports: clk, rst (sync, high), d async in; rise/fall one-cycle pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], d};
        end
    end

    assign rise = sh[1] & ~sh[2];
    assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave to register-table write/read bridge, oversampled on clk.
// Ports: spi_* pins, spi_req/ack/addr/din/dout arbiter side, busy,
// sticky ovr_err/to_err. Macro SPI_ACK_TIMEOUT_EN enables the ack timeout.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_req,
    input  logic        spi_ack,
    output logic [6:0]  spi_addr,
    output logic [15:0] spi_din,
    input  logic [15:0] spi_dout,
    output logic        busy,
    output logic        ovr_err,
    output logic        to_err
);

    // One width for both the read-latency and the ack-timeout counters.
    localparam int CNT_W =
        cnt_width((RD_LAT > TIMEOUT) ? RD_LAT : TIMEOUT);

    logic            sclk_rise;
    logic            sclk_fall;
    logic [1:0]      cs_sync;
    logic [1:0]      mosi_sync;
    logic            cs_d;
    logic            cs_n_s;
    logic            mosi_s;
    logic            cs_fall;

    frame_st_e       state;
    frame_st_e       state_nxt;
    logic [4:0]      bit_cnt;
    logic [15:0]     rx;
    logic [15:0]     tx;
    logic [CNT_W-1:0] wait_cnt;
    logic            cmd_w;
    logic [6:0]      cmd_addr;
    logic            rd_blk;
    logic            cmd_hit;
    logic            cap;
    logic            frame_done;
    logic            to_hit;

    spi_sync_edge u_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (spi_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= 2'b11;
            cs_d      <= 1'b1;
            mosi_sync <= 2'b00;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs_n};
            cs_d      <= cs_sync[1];
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign cs_n_s  = cs_sync[1];
    assign mosi_s  = mosi_sync[1];
    assign cs_fall = cs_d & ~cs_n_s;
    assign busy    = spi_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cmd_hit    = 1'b0;
        cap        = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cs_fall) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (cs_n_s) begin
                    state_nxt = ST_IDLE;
                end else if (bit_cnt == 5'(CMD_BITS)) begin
                    cmd_hit   = 1'b1;
                    state_nxt = rx[W_CMD_POS] ? ST_DATA : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cs_n_s) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == CNT_W'(RD_LAT - 1)) begin
                    cap       = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // A completed frame wins over a simultaneous cs_n release.
                if (bit_cnt == 5'(FRAME_BITS)) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_DONE;
                end else if (cs_n_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (cs_n_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            wait_cnt <= '0;
            cmd_w    <= 1'b0;
            cmd_addr <= '0;
            rd_blk   <= 1'b0;
            spi_miso <= 1'b0;
            spi_req  <= 1'b0;
            spi_addr <= '0;
            spi_din  <= '0;
            ovr_err  <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (sclk_rise && bit_cnt < 5'(FRAME_BITS)) begin
                bit_cnt <= bit_cnt + 5'd1;
                rx      <= {rx[14:0], mosi_s};
            end

            wait_cnt <= (state == ST_RD_WAIT) ?
                        wait_cnt + CNT_W'(1) : '0;

            if (cmd_hit) begin
                cmd_w    <= rx[W_CMD_POS];
                cmd_addr <= rx[W_CMD_POS-1:0];
                rd_blk   <= spi_req;
                tx       <= '0;
                // A read must not disturb the address of a pending write.
                if (!rx[W_CMD_POS]) begin
                    if (spi_req) ovr_err  <= 1'b1;
                    else         spi_addr <= rx[W_CMD_POS-1:0];
                end
            end else if (cap) begin
                tx <= rd_blk ? 16'h0000 : spi_dout;
            end else if (state == ST_DATA && sclk_fall) begin
                tx <= {tx[14:0], 1'b0};
            end

            if (state == ST_DATA) begin
                if (sclk_fall) spi_miso <= tx[15];
            end else begin
                spi_miso <= 1'b0;
            end

            if (spi_req && (spi_ack || to_hit)) spi_req <= 1'b0;

            if (frame_done && cmd_w) begin
                if (spi_req) begin
                    ovr_err <= 1'b1;
                end else begin
                    spi_req  <= 1'b1;
                    spi_addr <= cmd_addr;
                    spi_din  <= rx;
                end
            end
        end
    end

`ifdef SPI_ACK_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || !spi_req) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign to_hit = spi_req && (to_cnt == CNT_W'(TIMEOUT - 1));

    // An ack landing on the timeout cycle counts as success.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_err <= 1'b0;
        end else if (to_hit && !spi_ack) begin
            to_err <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: vector table of write/read frames
// plus hand-written abort, overrun, timeout and reset sequences.
module tb_spi_reg_bridge;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_req;
    logic        spi_ack;
    logic [6:0]  spi_addr;
    logic [15:0] spi_din;
    logic [15:0] spi_dout;
    logic        busy;
    logic        ovr_err;
    logic        to_err;

    int n_chk  = 0;
    int n_fail = 0;
    int req_len = 0;

    always #5 clk = ~clk;

    spi_reg_bridge #(.RD_LAT(2), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_req  (spi_req),
        .spi_ack  (spi_ack),
        .spi_addr (spi_addr),
        .spi_din  (spi_din),
        .spi_dout (spi_dout),
        .busy     (busy),
        .ovr_err  (ovr_err),
        .to_err   (to_err)
    );

    // Register table model.
    always_comb begin
        case (spi_addr)
            7'h10:   spi_dout = 16'h1234;
            7'h2A:   spi_dout = 16'hC0DE;
            7'h7F:   spi_dout = 16'h8001;
            default: spi_dout = 16'h5A5A;
        endcase
    end

    // Cycles spi_req has been high, as seen just after each edge.
    always @(posedge clk) req_len <= spi_req ? req_len + 1 : 0;

    typedef struct {
        logic        w;
        logic [6:0]  addr;
        logic [15:0] data;
        int          ack_dly;
        logic [23:0] exp_miso;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic spi_xfer(input logic [23:0] f, input int nbits,
                            output logic [23:0] mi);
        mi = '0;
        spi_cs_n = 1'b0;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = f[23-i];
            tick(HALF);
            spi_sclk = 1'b1;
            mi[23-i] = spi_miso;
            tick(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_end();
        tick(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tick(2 * HALF);
    endtask

    task automatic pulse_ack();
        spi_ack = 1'b1;
        tick(1);
        spi_ack = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int k;
        k = 0;
        while (spi_req !== 1'b1 && k < 200) begin
            tick(1);
            k++;
        end
        chk(nm, 32'(spi_req), 32'd1);
    endtask

    task automatic write_frame(input logic [6:0] a, input logic [15:0] d);
        logic [23:0] mi;
        spi_xfer({1'b1, a, d}, 24, mi);
        cs_end();
    endtask

    initial begin
        logic [23:0] mi;
        logic [23:0] fr;

        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] mi;
        logic [23:0] fr;
        int k;

        vecs[0] = '{1'b1, 7'h05, 16'hA5C3, 3, 24'h000000};
        vecs[1] = '{1'b0, 7'h10, 16'h0000, 0, 24'h001234};
        vecs[2] = '{1'b1, 7'h7F, 16'hFFFF, 0, 24'h000000};
        vecs[3] = '{1'b0, 7'h2A, 16'h0000, 0, 24'h00C0DE};
        vecs[4] = '{1'b1, 7'h00, 16'h0001, 1, 24'h000000};
        vecs[5] = '{1'b0, 7'h7F, 16'h0000, 0, 24'h008001};

        rst = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        spi_ack = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("rst_outs", {13'd0, spi_miso, spi_req, busy, ovr_err,
            to_err, spi_addr, spi_din[7:0]}, 32'd0);
        chk("rst_din", 32'(spi_din), 32'd0);
        tick(4);

        for (int i = 0; i < 6; i++) begin
            fr = {vecs[i].w, vecs[i].addr, vecs[i].data};
            spi_xfer(fr, 24, mi);
            cs_end();
            chk("vec_miso", 32'(mi), 32'(vecs[i].exp_miso));
            chk("vec_miso_idle", 32'(spi_miso), 32'd0);
            if (vecs[i].w) begin
                chk("vec_req", 32'(spi_req), 32'd1);
                chk("vec_busy", 32'(busy), 32'd1);
                chk("vec_addr", 32'(spi_addr), 32'(vecs[i].addr));
                chk("vec_din", 32'(spi_din), 32'(vecs[i].data));
                tick(vecs[i].ack_dly);
                chk("vec_hold", {spi_req, 8'd0, spi_addr, spi_din},
                    {1'b1, 8'd0, vecs[i].addr, vecs[i].data});
                pulse_ack();
                chk("vec_req_clr", 32'(spi_req), 32'd0);
                chk("vec_busy_clr", 32'(busy), 32'd0);
            end else begin
                chk("vec_rd_addr", 32'(spi_addr), 32'(vecs[i].addr));
                chk("vec_rd_noreq", 32'(spi_req), 32'd0);
            end
        end
        chk("no_ovr", 32'(ovr_err), 32'd0);

        // Abort after 13 bits, then a normal write.
        spi_xfer({1'b1, 7'h33, 16'hFFFF}, 13, mi);
        cs_end();
        tick(20);
        chk("abort_noreq", 32'(spi_req), 32'd0);
        write_frame(7'h06, 16'h1357);
        chk("abort_next", {spi_req, 8'd0, spi_addr, spi_din},
            {1'b1, 8'd0, 7'h06, 16'h1357});
        pulse_ack();

        // Back-to-back writes with ack withheld, then a blocked read.
        write_frame(7'h11, 16'h1111);
        write_frame(7'h22, 16'h2222);
        chk("ovr_err", 32'(ovr_err), 32'd1);
        chk("ovr_hold", {spi_req, 8'd0, spi_addr, spi_din},
            {1'b1, 8'd0, 7'h11, 16'h1111});
        spi_xfer({1'b0, 7'h10, 16'h0000}, 24, mi);
        cs_end();
        chk("busy_rd_miso", 32'(mi), 32'd0);
        chk("busy_rd_addr", 32'(spi_addr), 32'h11);
        pulse_ack();
        chk("ovr_req_clr", 32'(spi_req), 32'd0);

        // Stray ack with nothing pending.
        pulse_ack();
        tick(2);
        chk("stray_ack", {spi_req, busy}, 32'd0);

`ifdef SPI_ACK_TIMEOUT_EN
        spi_xfer({1'b1, 7'h50, 16'h0050}, 24, mi);
        wait_req("to_win_req");
        k = 0;
        while (req_len != 15 && spi_req && k < 100) begin
            tick(1);
            k++;
        end
        chk("to_win_align", 32'(req_len), 32'd15);
        pulse_ack();
        chk("to_win_clr", 32'(spi_req), 32'd0);
        chk("to_win_err", 32'(to_err), 32'd0);
        cs_end();

        spi_xfer({1'b1, 7'h51, 16'h0051}, 24, mi);
        wait_req("to_req");
        k = 0;
        while (spi_req && k < 100) begin
            tick(1);
            k++;
        end
        chk("to_len", 32'(req_len), 32'd16);
        chk("to_err", 32'(to_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        cs_end();
`else
        write_frame(7'h52, 16'h0052);
        tick(300);
        chk("noto_held", {spi_req, 8'd0, spi_addr, spi_din},
            {1'b1, 8'd0, 7'h52, 16'h0052});
        chk("noto_err", 32'(to_err), 32'd0);
        pulse_ack();
        chk("noto_clr", 32'(spi_req), 32'd0);
`endif

        // Reset while a request is pending.
        write_frame(7'h44, 16'h4444);
        chk("rstreq_req", 32'(spi_req), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rstreq_outs", {13'd0, spi_miso, spi_req, busy, ovr_err,
            to_err, spi_addr, spi_din[7:0]}, 32'd0);
        chk("rstreq_din", 32'(spi_din), 32'd0);
        tick(3);
        pulse_ack();
        chk("rstreq_ack_ign", {spi_req, 8'd0, spi_addr}, 32'd0);
        write_frame(7'h45, 16'h0045);
        chk("rstreq_recover", {spi_req, 8'd0, spi_addr, spi_din},
            {1'b1, 8'd0, 7'h45, 16'h0045});
        pulse_ack();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
